operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter WIDTH, default 8, data width of registers, immediate and operands.
REQ-002 Parameter NREGS, default 8, register count; address width is log2(NREGS) bits (3 at default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream offers an operation this cycle.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 ra1, ra2  input  3 each  source register addresses for A and B.
REQ-008 imm  input  WIDTH  immediate operand.
REQ-009 use_imm  input  1  1 selects imm as B instead of register ra2.
REQ-010 op  input  3  requested ALU operation.
REQ-011 we, wa, wd  input  1/3/WIDTH  writeback enable, address, data from ALU result.
REQ-012 SrcA, SrcB  output  WIDTH each  registered ALU operands.
REQ-013 ULAControl  output  3  registered ALU operation select.
REQ-014 out_valid  output  1  SrcA/SrcB/ULAControl hold a valid operation.
REQ-015 out_ready  input  1  downstream consumes the operation this cycle.
REQ-016 op_err  output  1  sticky flag, illegal op seen.
REQ-017 issue_cnt  output  8  count of accepted operations.

Function
REQ-018 Register file: NREGS x WIDTH; register 0 SHALL always read 0; writes with wa=0 SHALL be ignored.
REQ-019 Write: at rising edge with we=1 and wa!=0, regs[wa] <= wd; independent of handshake state.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), combinational.
REQ-021 Accept = in_valid && in_ready; on accept SrcA, SrcB, ULAControl, out_valid=1 load at the same edge (latency 1 cycle).
REQ-022 Operand A SHALL be 0 if ra1=0, else wd if we=1 and wa=ra1 in the accept cycle (bypass), else regs[ra1].
REQ-023 Operand B SHALL be imm if use_imm=1, else the REQ-022 rule applied to ra2.
REQ-024 op 000-101 SHALL pass unchanged to ULAControl; op 110/111 SHALL load ULAControl=111 and set op_err=1 at the same edge.
REQ-025 op_err SHALL stay 1 until reset.
REQ-026 out_valid=1 and out_ready=0: SrcA, SrcB, ULAControl SHALL hold stable; writebacks to source registers SHALL NOT alter held operands.
REQ-027 out_ready=1 and no accept: out_valid SHALL clear at the edge; SrcA/SrcB/ULAControl retain last values.
REQ-028 Simultaneous consume and accept (out_valid=1, out_ready=1, in_valid=1): new operation SHALL load, out_valid stays 1, no bubble.
REQ-029 issue_cnt SHALL increment by 1 per accept, wrapping 255 -> 0.
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL clear all registers, SrcA, SrcB, ULAControl=000, out_valid, op_err, issue_cnt to 0; it takes priority over accept and write in that cycle.
REQ-032 in_ready SHALL read 1 during and after reset (out_valid=0).
REQ-033 Reset mid-operation SHALL drop a held, unconsumed operation with no output.

Verification
REQ-034 Write r3=0x25, r5=0x10; issue ra1=3, ra2=5, op=001, out_ready=1 -> next cycle SrcA=0x25, SrcB=0x10, ULAControl=001, out_valid=1, issue_cnt=1.
REQ-035 Same cycle we=1, wa=2, wd=0x7F with issue ra1=2, use_imm=1, imm=0x01 -> SrcA=0x7F, SrcB=0x01; r2 reads 0x7F afterwards.
REQ-036 out_ready=0 with op held; write r3=0xAA -> SrcA unchanged, in_ready=0, second in_valid not accepted, issue_cnt unchanged.
REQ-037 Write wa=0, wd=0xFF; issue ra1=0, ra2=0 -> SrcA=0x00, SrcB=0x00.
REQ-038 Issue op=110 -> ULAControl=111, op_err=1, stays 1 over following legal ops; rst -> op_err=0, out_valid=0, all registers 0.
REQ-039 256 back-to-back accepts with out_ready=1 -> out_valid continuously 1, issue_cnt returns to 0.

Source files
------------

// File: rtl/operand_stage.sv
// Operand fetch stage: register file with write bypass feeding a one-entry
// valid/ready output register that holds ALU operands and the operation select.
module operand_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 8,
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [2:0]       op,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ULAControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             op_err,
    output logic [7:0]       issue_cnt
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_src_a;
    logic [WIDTH-1:0] r_src_b;
    logic [2:0]       r_ctl;
    logic             r_valid;
    logic             r_err;
    logic [7:0]       r_cnt;

    logic             w_accept;
    logic             w_illegal;
    logic [2:0]       w_ctl;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_opnd_b;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_illegal = op[2] & op[1];
    assign w_ctl     = w_illegal ? 3'b111 : op;

    // Same-cycle writeback is forwarded so an issue never sees a stale register.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (ra1 != '0) begin
            w_rd_a = (we && (wa == ra1)) ? wd : r_regs[ra1];
        end
        if (ra2 != '0) begin
            w_rd_b = (we && (wa == ra2)) ? wd : r_regs[ra2];
        end
        w_opnd_b = use_imm ? imm : w_rd_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
            r_src_a <= '0;
            r_src_b <= '0;
            r_ctl   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (we && (wa != '0)) begin
                r_regs[wa] <= wd;
            end
            if (w_accept) begin
                r_src_a <= w_rd_a;
                r_src_b <= w_opnd_b;
                r_ctl   <= w_ctl;
                r_valid <= 1'b1;
                r_cnt   <= r_cnt + 8'd1;
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign SrcA       = r_src_a;
    assign SrcB       = r_src_b;
    assign ULAControl = r_ctl;
    assign out_valid  = r_valid;
    assign op_err     = r_err;
    assign issue_cnt  = r_cnt;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: queue scoreboard fed by a behavioural model,
// directed scenarios followed by randomized traffic.
module tb_operand_stage;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, use_imm, we, out_valid, out_ready, op_err;
    logic [2:0] ra1, ra2, op, wa, ULAControl;
    logic [7:0] imm, wd, SrcA, SrcB, issue_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] c;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] m_regs [8];
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic [7:0] m_cnt   = 8'd0;

    always #5 clk = ~clk;

    operand_stage #(.WIDTH(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ra1        (ra1),
        .ra2        (ra2),
        .imm        (imm),
        .use_imm    (use_imm),
        .op         (op),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ULAControl (ULAControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_err     (op_err),
        .issue_cnt  (issue_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Architectural read of a source register as seen by an issuing operation.
    function automatic logic [7:0] src(input logic [2:0] a);
        if (a == 3'd0) return 8'd0;
        if (we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    // Inputs are already applied at a falling edge; check state, advance the model
    // across the coming rising edge, then wait for the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("op_err", {31'd0, op_err}, {31'd0, m_err});
        chk("issue_cnt", {24'd0, issue_cnt}, {24'd0, m_cnt});
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 8'd0;
            sb.delete();
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                e.a = src(ra1);
                e.b = use_imm ? imm : src(ra2);
                e.c = (op >= 3'd6) ? 3'd7 : op;
                if (op >= 3'd6) m_err = 1'b1;
                sb.push_back(e);
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (we && (wa != 3'd0)) m_regs[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; use_imm = 1'b0; we = 1'b0; out_ready = 1'b0;
        ra1 = 3'd0; ra2 = 3'd0; op = 3'd0; wa = 3'd0; imm = 8'd0; wd = 8'd0;
    endtask

    task automatic issue(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] o);
        in_valid = 1'b1; ra1 = a1; ra2 = a2; op = o;
    endtask

    task automatic rnd();
        rst       = ($urandom_range(0, 99) == 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        ra1       = 3'($urandom_range(0, 7));
        ra2       = 3'($urandom_range(0, 7));
        use_imm   = $urandom_range(0, 1) == 1;
        imm       = 8'($urandom);
        op        = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7))
                                                 : 3'($urandom_range(0, 5));
        we        = $urandom_range(0, 1) == 1;
        wa        = 3'($urandom_range(0, 7));
        wd        = 8'($urandom);
    endtask

    // Monitor: whenever an operation is presented it must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("SrcA", {24'd0, SrcA}, {24'd0, sb[0].a});
                    chk("SrcB", {24'd0, SrcB}, {24'd0, sb[0].b});
                    chk("ULAControl", {29'd0, ULAControl}, {29'd0, sb[0].c});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        // Reset has priority over a concurrent issue and write.
        in_valid = 1'b1; we = 1'b1; wa = 3'd4; wd = 8'h99;
        step();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctl", {29'd0, ULAControl}, 32'd0);

        // Basic issue from written registers.
        idle(); we = 1'b1; wa = 3'd3; wd = 8'h25; step();
        idle(); we = 1'b1; wa = 3'd5; wd = 8'h10; step();
        idle(); out_ready = 1'b1; issue(3'd3, 3'd5, 3'b001); step();
        chk("d34_srca", {24'd0, SrcA}, 32'h25);
        chk("d34_srcb", {24'd0, SrcB}, 32'h10);
        chk("d34_ctl", {29'd0, ULAControl}, 32'd1);
        chk("d34_valid", {31'd0, out_valid}, 32'd1);
        chk("d34_cnt", {24'd0, issue_cnt}, 32'd1);

        // Write bypass into the issuing operation.
        idle(); out_ready = 1'b1; we = 1'b1; wa = 3'd2; wd = 8'h7F;
        issue(3'd2, 3'd0, 3'd0); use_imm = 1'b1; imm = 8'h01; step();
        chk("d35_srca", {24'd0, SrcA}, 32'h7F);
        chk("d35_srcb", {24'd0, SrcB}, 32'h01);
        idle(); out_ready = 1'b1; issue(3'd2, 3'd2, 3'd4); step();
        chk("d35_r2", {24'd0, SrcB}, 32'h7F);

        // Backpressure: held operand ignores later writeback and blocks issue.
        idle(); out_ready = 1'b1; issue(3'd3, 3'd5, 3'd2); step();
        idle(); we = 1'b1; wa = 3'd3; wd = 8'hAA; issue(3'd3, 3'd3, 3'd3); step();
        chk("d36_srca", {24'd0, SrcA}, 32'h25);
        chk("d36_ready", {31'd0, in_ready}, 32'd0);
        idle(); issue(3'd1, 3'd1, 3'd5); step();
        chk("d36_cnt", {24'd0, issue_cnt}, 32'd4);
        idle(); out_ready = 1'b1; step();
        chk("d36_drain", {31'd0, out_valid}, 32'd0);
        chk("d36_keep", {24'd0, SrcA}, 32'h25);
        idle(); out_ready = 1'b1; step();

        // Register 0 is hardwired.
        idle(); we = 1'b1; wa = 3'd0; wd = 8'hFF; step();
        idle(); out_ready = 1'b1; issue(3'd0, 3'd0, 3'd1);
        we = 1'b1; wa = 3'd0; wd = 8'hFF; step();
        chk("d37_srca", {24'd0, SrcA}, 32'h00);
        chk("d37_srcb", {24'd0, SrcB}, 32'h00);

        // Illegal op: sticky error until reset.
        idle(); out_ready = 1'b1; issue(3'd3, 3'd5, 3'b110); step();
        chk("d38_ctl", {29'd0, ULAControl}, 32'd7);
        chk("d38_err", {31'd0, op_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(); out_ready = 1'b1; issue(3'd3, 3'd5, 3'($urandom_range(0, 5))); step();
        end
        chk("d38_sticky", {31'd0, op_err}, 32'd1);
        idle(); issue(3'd1, 3'd1, 3'd1); step();
        idle(); rst = 1'b1; step();
        chk("d38_rst_err", {31'd0, op_err}, 32'd0);
        chk("d38_rst_valid", {31'd0, out_valid}, 32'd0);
        idle(); out_ready = 1'b1; issue(3'd3, 3'd5, 3'd0); step();
        chk("d38_rst_r3", {24'd0, SrcA}, 32'h00);
        chk("d38_rst_r5", {24'd0, SrcB}, 32'h00);

        // 256 back-to-back accepts wrap the counter to zero.
        idle(); rst = 1'b1; step();
        for (int i = 0; i < 256; i++) begin
            rnd(); rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; step();
            chk("d39_valid", {31'd0, out_valid}, 32'd1);
        end
        chk("d39_cnt", {24'd0, issue_cnt}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rnd();
            step();
        end
        idle(); out_ready = 1'b1; step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
